// File: rtl/pose_pkg.sv
// rtl/pose_pkg.sv - shared constants, FSM encoding and orientation stepping for the pose scheduler
// Purpose: types and helpers shared by triangle_pose_scheduler and its bench.
// Ports: none (package).
package pose_pkg;

    localparam int NUM_ORIENTATIONS = 24;
    localparam int HALF_TURN        = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } sched_state_t;

    // One 15-degree step from cur towards tgt along the shorter way round.
    // An exact half turn goes +1. Both arguments must already be 0..23.
    function automatic logic [4:0] orient_step(input logic [4:0] cur, input logic [4:0] tgt);
        logic [5:0] diff;
        diff = {1'b0, tgt} + 6'(NUM_ORIENTATIONS) - {1'b0, cur};
        if (diff >= 6'(NUM_ORIENTATIONS)) begin
            diff = diff - 6'(NUM_ORIENTATIONS);
        end
        if (diff == 6'd0) begin
            orient_step = cur;
        end else if (diff <= 6'(HALF_TURN)) begin
            orient_step = (cur == 5'(NUM_ORIENTATIONS - 1)) ? 5'd0 : cur + 5'd1;
        end else begin
            orient_step = (cur == 5'd0) ? 5'(NUM_ORIENTATIONS - 1) : cur - 5'd1;
        end
    endfunction

endpackage

// File: rtl/triangle_pose_scheduler_if.sv
// rtl/triangle_pose_scheduler_if.sv - target pose valid/ready channel
// Purpose: carries target poses from the tracking logic to the scheduler.
// Signals: target_valid, target_ready, target_x[11:0], target_y[11:0], target_orientation[4:0].
// Modports: master (tracking logic side), slave (scheduler side).
interface triangle_pose_scheduler_if;

    logic        target_valid;
    logic        target_ready;
    logic [11:0] target_x;
    logic [11:0] target_y;
    logic [4:0]  target_orientation;

    modport master (
        output target_valid,
        output target_x,
        output target_y,
        output target_orientation,
        input  target_ready
    );

    modport slave (
        input  target_valid,
        input  target_x,
        input  target_y,
        input  target_orientation,
        output target_ready
    );

endinterface

// File: rtl/vsync_edge_detect.sv
// rtl/vsync_edge_detect.sv - frame boundary pulse from the rising edge of vsync
// Purpose: fb is high for the single cycle in which vsync=1 and it was 0 the cycle before.
// Ports: clock, reset_n (async active-low), vsync (synchronous to clock) -> fb.
module vsync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic vsync,
    output logic fb
);

    logic vsync_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync;
        end
    end

    assign fb = vsync & ~vsync_prev;

endmodule

// File: rtl/triangle_pose_scheduler.sv
// rtl/triangle_pose_scheduler.sv - frame-synchronous pose commit and orientation slew for the triangle renderer
// Purpose: accepts target poses, commits position on frame boundaries and slews orientation
//          one step every FRAMES_PER_STEP frames along the shortest path mod 24.
// Ports: clock, reset_n (async active-low), vsync, target (slave channel),
//        center_x/center_y/orientation (renderer pose), settled, bad_orientation (1-cycle pulse).
module triangle_pose_scheduler
    import pose_pkg::*;
#(
    parameter int          FRAMES_PER_STEP = 4,
    parameter logic [11:0] RESET_X         = 12'd512,
    parameter logic [11:0] RESET_Y         = 12'd384
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           vsync,
    triangle_pose_scheduler_if.slave       target,
    output logic [11:0]                    center_x,
    output logic [11:0]                    center_y,
    output logic [4:0]                     orientation,
    output logic                           settled,
    output logic                           bad_orientation
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

    sched_state_t state_q, state_nxt;
    logic [11:0]  pend_x_q, pend_y_q, pend_x_nxt, pend_y_nxt;
    logic [4:0]   pend_o_q, pend_o_nxt;
    logic [11:0]  x_nxt, y_nxt;
    logic [4:0]   o_nxt;
    logic [7:0]   cnt_q, cnt_nxt;
    logic         ready_q;
    logic         fb;
    logic         accept;
    logic         orient_bad;
    logic         match_nxt;

    vsync_edge_detect u_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .vsync   (vsync),
        .fb      (fb)
    );

    assign target.target_ready = ready_q;
    assign accept     = target.target_valid & ready_q;
    assign orient_bad = target.target_orientation >= 5'(NUM_ORIENTATIONS);

    // Commit reads the pending registers before this cycle's accept lands in them,
    // so a target accepted on a frame boundary waits for the following one.
    always_comb begin
        x_nxt      = center_x;
        y_nxt      = center_y;
        o_nxt      = orientation;
        cnt_nxt    = cnt_q;
        pend_x_nxt = pend_x_q;
        pend_y_nxt = pend_y_q;
        pend_o_nxt = pend_o_q;
        state_nxt  = state_q;

        if (state_q == TRACK && fb) begin
            x_nxt = pend_x_q;
            y_nxt = pend_y_q;
        end

        // Cadence only restarts while orientation is settled; a retarget mid-slew keeps the count.
        if (orientation == pend_o_q) begin
            cnt_nxt = 8'd0;
        end else if (state_q == TRACK && fb) begin
            if (cnt_q == LAST_FRAME) begin
                o_nxt   = orient_step(orientation, pend_o_q);
                cnt_nxt = 8'd0;
            end else begin
                cnt_nxt = cnt_q + 8'd1;
            end
        end

        if (accept) begin
            pend_x_nxt = target.target_x;
            pend_y_nxt = target.target_y;
            if (!orient_bad) begin
                pend_o_nxt = target.target_orientation;
            end
        end

        match_nxt = (x_nxt == pend_x_nxt) && (y_nxt == pend_y_nxt) && (o_nxt == pend_o_nxt);
        state_nxt = match_nxt ? IDLE : TRACK;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            center_x        <= RESET_X;
            center_y        <= RESET_Y;
            orientation     <= 5'd0;
            pend_x_q        <= RESET_X;
            pend_y_q        <= RESET_Y;
            pend_o_q        <= 5'd0;
            cnt_q           <= 8'd0;
            ready_q         <= 1'b0;
            settled         <= 1'b1;
            bad_orientation <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            center_x        <= x_nxt;
            center_y        <= y_nxt;
            orientation     <= o_nxt;
            pend_x_q        <= pend_x_nxt;
            pend_y_q        <= pend_y_nxt;
            pend_o_q        <= pend_o_nxt;
            cnt_q           <= cnt_nxt;
            ready_q         <= 1'b1;
            settled         <= match_nxt;
            bad_orientation <= accept & orient_bad;
        end
    end

endmodule
